// File: rtl/matrix_result_streamer.sv
// Buffers 4x4 result matrices from the DSP and drains them as a row-major word stream
// under valid/ready backpressure; results arriving while the buffer is full are counted and dropped.
module matrix_result_streamer #(
    parameter int unsigned W     = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                          clk_100mhz,
    input  logic                          reset,
    input  logic [N-1:0][N-1:0][W-1:0]    p2,
    input  logic                          res_valid,
    input  logic                          res_ovf,
    output logic [W-1:0]                  out_data,
    output logic [$clog2(N*N)-1:0]        out_index,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          out_ovf,
    output logic                          full,
    output logic [CNT_W-1:0]              drop_count
);

    localparam int unsigned WORDS = N * N;
    localparam int unsigned IW    = $clog2(WORDS);
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                       state;
    logic [WORDS-1:0][W-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]             ovf_mem;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                count;

    logic                         hs_c;
    logic                         pop_c;
    logic                         push_c;
    logic                         drop_c;
    logic [CW-1:0]                count_next_c;
    logic [PW-1:0]                rd_next_c;
    logic [IW-1:0]                idx_next_c;

    // Popping the last word frees a slot in the same edge, so a coincident capture is accepted.
    always_comb begin
        hs_c         = out_valid && out_ready;
        pop_c        = (state == STREAM) && hs_c && (out_index == IW'(WORDS - 1));
        push_c       = res_valid && ((count < CW'(DEPTH)) || pop_c);
        drop_c       = res_valid && !push_c;
        count_next_c = CW'(count + CW'(push_c) - CW'(pop_c));
        rd_next_c    = PW'(rd_ptr + PW'(1));
        idx_next_c   = IW'(out_index + IW'(1));
    end

    // Matrix storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk_100mhz) begin
        if (push_c) begin
            mem[wr_ptr]     <= p2;
            ovf_mem[wr_ptr] <= res_ovf;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            drop_count <= '0;
            out_data   <= '0;
            out_index  <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= PW'(wr_ptr + PW'(1));
            end
            count <= count_next_c;
            full  <= (count_next_c == CW'(DEPTH));
            if (drop_c && (drop_count != '1)) begin
                drop_count <= CNT_W'(drop_count + CNT_W'(1));
            end

            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (count != '0) begin
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_data  <= mem[rd_ptr][0];
                        out_ovf   <= ovf_mem[rd_ptr];
                        out_last  <= (WORDS == 1);
                    end
                end
                STREAM: begin
                    if (hs_c && !pop_c) begin
                        out_index <= idx_next_c;
                        out_data  <= mem[rd_ptr][idx_next_c];
                        out_last  <= (idx_next_c == IW'(WORDS - 1));
                    end else if (pop_c) begin
                        rd_ptr    <= rd_next_c;
                        out_index <= '0;
                        out_last  <= (WORDS == 1);
                        if (count > CW'(1)) begin
                            out_data <= mem[rd_next_c][0];
                            out_ovf  <= ovf_mem[rd_next_c];
                        end else if (push_c) begin
                            // Next frame is being captured this very edge: bypass storage.
                            out_data <= p2[0][0];
                            out_ovf  <= res_ovf;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer: latency, backpressure, frame chaining,
// full/drop behaviour, drop counter saturation and mid-frame reset.
module tb_matrix_result_streamer;

    logic                        clk_100mhz = 1'b0;
    logic                        reset;
    logic [3:0][3:0][15:0]       p2;
    logic                        res_valid;
    logic                        res_ovf;
    logic [15:0]                 out_data;
    logic [3:0]                  out_index;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic                        out_ovf;
    logic                        full;
    logic [7:0]                  drop_count;

    int checks = 0;
    int errors = 0;

    matrix_result_streamer dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .p2         (p2),
        .res_valid  (res_valid),
        .res_ovf    (res_ovf),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_ovf    (out_ovf),
        .full       (full),
        .drop_count (drop_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Element [r][c] = (r*4+c)*256 + tag, so word i of a frame is i*256 + tag.
    task automatic set_mat(input int tag, input logic ovf);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                p2[r][c] = 16'((r * 4 + c) * 256 + tag);
        res_ovf = ovf;
    endtask

    task automatic expect_word(input string tag, input int idx, input int mtag, input logic ovf);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_index"}, 32'(out_index), 32'(idx));
        chk({tag, "_data"},  32'(out_data),  32'(idx * 256 + mtag));
        chk({tag, "_last"},  32'(out_last),  32'(idx == 15));
        chk({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    initial begin
        int idx;
        reset     = 1'b1;
        res_valid = 1'b0;
        out_ready = 1'b0;
        set_mat(0, 1'b0);
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_ovf",   32'(out_ovf),   32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_full",  32'(full),      32'd0);
        chk("rst_drop",  32'(drop_count), 32'd0);
        reset = 1'b0;
        tick();

        // 1: single frame, consumer always ready
        set_mat(0, 1'b0);
        out_ready = 1'b1;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t1_lat0", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            expect_word("t1", i, 0, 1'b0);
            tick();
        end
        chk("t1_idle", 32'(out_valid), 32'd0);
        chk("t1_full", 32'(full), 32'd0);

        // 2: ready pattern 1,0,0 repeating; words held while not ready
        set_mat(0, 1'b0);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        idx = 0;
        for (int cyc = 0; cyc < 60 && idx < 16; cyc++) begin
            expect_word("t2", idx, 0, 1'b0);
            out_ready = (cyc % 3 == 0);
            if (out_ready) idx++;
            tick();
        end
        chk("t2_count", 32'(idx), 32'd16);
        chk("t2_idle", 32'(out_valid), 32'd0);

        // 3: back-to-back frames, ovf tag follows each frame, no bubble
        out_ready = 1'b1;
        set_mat(1, 1'b1);
        res_valid = 1'b1;
        tick();
        set_mat(2, 1'b0);
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            expect_word("t3", i % 16, (i < 16) ? 1 : 2, i < 16);
            tick();
        end
        chk("t3_idle", 32'(out_valid), 32'd0);

        // 4: consumer stalled, third result dropped
        out_ready = 1'b0;
        set_mat(3, 1'b0);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t4_full1", 32'(full), 32'd0);
        tick();
        set_mat(4, 1'b1);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t4_full2", 32'(full), 32'd1);
        tick();
        set_mat(5, 1'b0);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t4_drop", 32'(drop_count), 32'd1);
        chk("t4_full3", 32'(full), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            expect_word("t4", i % 16, (i < 16) ? 3 : 4, i >= 16);
            tick();
        end
        chk("t4_idle", 32'(out_valid), 32'd0);
        chk("t4_drop_end", 32'(drop_count), 32'd1);
        chk("t4_full_end", 32'(full), 32'd0);

        // 5: buffer full, capture coincides with last-word pop
        out_ready = 1'b0;
        set_mat(6, 1'b0);
        res_valid = 1'b1;
        tick();
        set_mat(7, 1'b1);
        tick();
        res_valid = 1'b0;
        chk("t5_full", 32'(full), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_word("t5a", i, 6, 1'b0);
            if (i == 15) begin
                set_mat(8, 1'b0);
                res_valid = 1'b1;
            end
            tick();
            res_valid = 1'b0;
        end
        chk("t5_drop", 32'(drop_count), 32'd1);
        chk("t5_full2", 32'(full), 32'd1);
        for (int i = 0; i < 32; i++) begin
            expect_word("t5b", i % 16, (i < 16) ? 7 : 8, i < 16);
            tick();
        end
        chk("t5_idle", 32'(out_valid), 32'd0);

        // drop counter saturates at 255
        out_ready = 1'b0;
        set_mat(11, 1'b0);
        res_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        res_valid = 1'b0;
        chk("sat_drop", 32'(drop_count), 32'd255);
        chk("sat_full", 32'(full), 32'd1);

        // 6: reset at word 7 of a frame
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            expect_word("t6a", i, 11, 1'b0);
            tick();
        end
        expect_word("t6b", 7, 11, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_full",  32'(full),      32'd0);
        chk("t6_drop",  32'(drop_count), 32'd0);
        chk("t6_index", 32'(out_index), 32'd0);
        set_mat(12, 1'b1);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t6_lat0", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            expect_word("t6c", i, 12, 1'b1);
            tick();
        end
        chk("t6_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
